// File: rtl/gesture_sequencer.sv
// Debounces gesture codes from the classifier and slews the five finger pulse
// widths toward the selected gesture at a bounded rate per tick.
module gesture_sequencer #(
  parameter int          TICK_CYCLES  = 50000,
  parameter logic [15:0] STEP_US      = 16'd10,
  parameter int          STABLE_COUNT = 3,
  parameter logic [15:0] WIDTH_MIN    = 16'd1000,
  parameter logic [15:0] WIDTH_MAX    = 16'd2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gesture_valid,
  input  logic [7:0]  gesture,
  output logic        gesture_ready,
  output logic [15:0] width_thumb,
  output logic [15:0] width_index,
  output logic [15:0] width_middle,
  output logic [15:0] width_ring,
  output logic [15:0] width_pinky,
  output logic        busy,
  output logic        done,
  output logic [1:0]  current_gesture
);

  localparam int TW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CNT_W = $clog2(STABLE_COUNT + 1);

  typedef enum logic [1:0] {IDLE, QUALIFY, RAMP} state_t;

  state_t            state, next_state;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [CNT_W-1:0]  count, next_count, count_inc;
  logic [1:0]        candidate, next_candidate;
  logic              load, ramp_end, all_done;
  logic              accept, code_ok;
  logic [1:0]        code;
  logic [15:0]       width      [5];
  logic [15:0]       target     [5];
  logic [15:0]       width_next [5];

  function automatic logic [15:0] clamp(input logic [15:0] w);
    if (w < WIDTH_MIN) return WIDTH_MIN;
    if (w > WIDTH_MAX) return WIDTH_MAX;
    return w;
  endfunction

  // Finger order 0..4 = thumb, index, middle, ring, pinky.
  function automatic logic [15:0] table_width(input logic [1:0] g, input logic [2:0] f);
    logic [15:0] w;
    w = 16'd1500;
    case (g)
      2'd1: case (f)
        3'd0, 3'd1: w = 16'd1900;
        3'd2:       w = 16'd1800;
        default:    w = 16'd2000;
      endcase
      2'd2: case (f)
        3'd0, 3'd2: w = 16'd1000;
        3'd1, 3'd3: w = 16'd1100;
        default:    w = 16'd1300;
      endcase
      2'd3: case (f)
        3'd0:    w = 16'd1800;
        3'd1:    w = 16'd1100;
        3'd2:    w = 16'd1000;
        default: w = 16'd2000;
      endcase
      default: w = 16'd1500;
    endcase
    return clamp(w);
  endfunction

  // Differences are only formed after the magnitude compare, so nothing wraps.
  function automatic logic [15:0] slew(input logic [15:0] w, input logic [15:0] t);
    if (w < t) return ((t - w) > STEP_US) ? (w + STEP_US) : t;
    if (w > t) return ((w - t) > STEP_US) ? (w - STEP_US) : t;
    return w;
  endfunction

  assign tick      = (tick_cnt == TW'(TICK_CYCLES - 1));
  assign accept    = gesture_valid && gesture_ready;
  assign code      = gesture[1:0];
  assign code_ok   = (gesture == 8'd1) || (gesture == 8'd2) || (gesture == 8'd3);
  assign count_inc = count + 1'b1;

  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      width_next[i] = (state == RAMP && tick) ? slew(width[i], target[i]) : width[i];
      if (width_next[i] != target[i]) all_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      tick_cnt        <= '0;
      count           <= '0;
      candidate       <= 2'd0;
      current_gesture <= 2'd0;
      done            <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        width[i]  <= 16'd1500;
        target[i] <= 16'd1500;
      end
    end else begin
      state     <= next_state;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      count     <= next_count;
      candidate <= next_candidate;
      done      <= ramp_end;
      if (ramp_end) current_gesture <= candidate;
      for (int i = 0; i < 5; i++) begin
        width[i] <= width_next[i];
        if (load) target[i] <= table_width(next_candidate, 3'(i));
      end
    end
  end

  always_comb begin
    next_state     = state;
    next_count     = count;
    next_candidate = candidate;
    load           = 1'b0;
    ramp_end       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && code_ok && code != current_gesture) begin
          next_candidate = code;
          next_count     = CNT_W'(1);
          if (STABLE_COUNT == 1) begin
            load       = 1'b1;
            next_state = RAMP;
          end else begin
            next_state = QUALIFY;
          end
        end
      end
      QUALIFY: begin
        if (accept) begin
          if (!code_ok) begin
            next_state = IDLE;
            next_count = '0;
          end else if (code == candidate) begin
            next_count = count_inc;
            if (count_inc == CNT_W'(STABLE_COUNT)) begin
              load       = 1'b1;
              next_state = RAMP;
            end
          end else if (code == current_gesture) begin
            next_state = IDLE;
            next_count = '0;
          end else begin
            next_candidate = code;
            next_count     = CNT_W'(1);
          end
        end
      end
      RAMP: begin
        if (tick && all_done) begin
          next_state = IDLE;
          next_count = '0;
          ramp_end   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    gesture_ready = !reset && (state != RAMP);
    busy          = (state == RAMP);
  end

  assign width_thumb  = width[0];
  assign width_index  = width[1];
  assign width_middle = width[2];
  assign width_ring   = width[3];
  assign width_pinky  = width[4];

endmodule

// File: tb/tb_gesture_sequencer.sv
// Scoreboard bench for gesture_sequencer: committed gestures queue their final
// widths, and each ramp is followed tick by tick against a small slew model.
module tb_gesture_sequencer;
  localparam int          TICK = 4;
  localparam logic [15:0] STEP = 16'd100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gesture_valid = 1'b0;
  logic [7:0]  gesture = 8'h00;
  logic        gesture_ready, busy, done;
  logic [15:0] width_thumb, width_index, width_middle, width_ring, width_pinky;
  logic [1:0]  current_gesture;
  logic [79:0] widths_now;

  gesture_sequencer #(
    .TICK_CYCLES(TICK), .STEP_US(STEP), .STABLE_COUNT(3),
    .WIDTH_MIN(16'd1000), .WIDTH_MAX(16'd2000)
  ) dut (
    .clk(clk), .reset(reset), .gesture_valid(gesture_valid), .gesture(gesture),
    .gesture_ready(gesture_ready), .width_thumb(width_thumb), .width_index(width_index),
    .width_middle(width_middle), .width_ring(width_ring), .width_pinky(width_pinky),
    .busy(busy), .done(done), .current_gesture(current_gesture)
  );

  always #5 clk = ~clk;
  assign widths_now = {width_thumb, width_index, width_middle, width_ring, width_pinky};

  typedef struct packed {logic [1:0] g; logic [79:0] w;} exp_t;
  exp_t        sb[$];
  logic [79:0] snaps[$];
  logic [79:0] exp_snaps[$];
  int          gaps[$];
  int          checks = 0;
  int          errors = 0;
  logic        timed_out, done_after, busy_at_done, ready_at_done;
  logic [1:0]  cg_at_done;
  logic [79:0] w_at_done;
  localparam logic [79:0] ALL1500 = {5{16'd1500}};

  function automatic logic [79:0] table_of(input int g);
    case (g)
      1: return {16'd1900, 16'd1900, 16'd1800, 16'd2000, 16'd2000};
      2: return {16'd1000, 16'd1100, 16'd1000, 16'd1100, 16'd1300};
      3: return {16'd1800, 16'd1100, 16'd1000, 16'd2000, 16'd2000};
      default: return ALL1500;
    endcase
  endfunction

  function automatic logic [79:0] model_tick(input logic [79:0] cur, input logic [79:0] tgt);
    logic [79:0] nxt;
    logic [15:0] w, t;
    nxt = cur;
    for (int f = 0; f < 5; f++) begin
      w = cur[f*16 +: 16];
      t = tgt[f*16 +: 16];
      if (t > w) nxt[f*16 +: 16] = (t - w >= STEP) ? w + STEP : t;
      else if (w > t) nxt[f*16 +: 16] = (w - t >= STEP) ? w - STEP : t;
    end
    return nxt;
  endfunction

  task automatic build_expect(input logic [79:0] start, input logic [79:0] tgt);
    logic [79:0] w;
    exp_snaps.delete();
    w = start;
    for (int k = 0; k < 50 && w != tgt; k++) begin
      w = model_tick(w, tgt);
      exp_snaps.push_back(w);
    end
  endtask

  task automatic send_beat(input logic [7:0] code);
    @(negedge clk);
    gesture_valid = 1'b1;
    gesture       = code;
    @(posedge clk);
    #1;
    gesture_valid = 1'b0;
    gesture       = 8'h00;
  endtask

  task automatic push_expect(input int g);
    exp_t e;
    e.g = 2'(g);
    e.w = table_of(g);
    sb.push_back(e);
  endtask

  // Records every width change and the outputs seen when done rises.
  task automatic watch_ramp(input int max_cycles);
    logic [79:0] prev;
    int last;
    snaps.delete();
    gaps.delete();
    timed_out = 1'b1;
    prev = widths_now;
    last = 0;
    for (int c = 1; c <= max_cycles; c++) begin
      @(negedge clk);
      if (widths_now != prev) begin
        snaps.push_back(widths_now);
        gaps.push_back(c - last);
        last = c;
        prev = widths_now;
      end
      if (done) begin
        timed_out     = 1'b0;
        busy_at_done  = busy;
        ready_at_done = gesture_ready;
        cg_at_done    = current_gesture;
        w_at_done     = widths_now;
        break;
      end
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (gesture_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", gesture_ready); end
    checks++; if (widths_now !== ALL1500) begin errors++; $display("FAIL reset_widths got %h want %h", widths_now, ALL1500); end
    checks++; if ({busy, done, current_gesture} !== 4'b0000) begin errors++; $display("FAIL reset_flags got busy=%b done=%b cg=%0d want 0 0 0", busy, done, current_gesture); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (gesture_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", gesture_ready); end
  endtask

  task automatic test_rock();
    exp_t e;
    build_expect(widths_now, table_of(1));
    repeat (3) send_beat(8'h01);
    push_expect(1);
    checks++; if ({busy, gesture_ready} !== 2'b10) begin errors++; $display("FAIL rock_busy got busy=%b ready=%b want 1 0", busy, gesture_ready); end
    watch_ramp(200);
    checks++; if (timed_out) begin errors++; $display("FAIL rock_timeout got no done want done within 200 cycles"); end
    checks++; if (snaps.size() != 5) begin errors++; $display("FAIL rock_ticks got %0d want 5", snaps.size()); end
    for (int k = 0; k < snaps.size() && k < exp_snaps.size(); k++) begin
      checks++; if (snaps[k] !== exp_snaps[k]) begin errors++; $display("FAIL rock_tick%0d got %h want %h", k + 1, snaps[k], exp_snaps[k]); end
    end
    for (int k = 1; k < gaps.size(); k++) begin
      checks++; if (gaps[k] != TICK) begin errors++; $display("FAIL rock_gap%0d got %0d want %0d", k, gaps[k], TICK); end
    end
    if (snaps.size() >= 4) begin
      checks++; if (snaps[3][79:64] !== 16'd1900 || snaps[2][47:32] !== 16'd1800) begin errors++; $display("FAIL rock_thumb_middle got %h want thumb 1900 at tick4, middle 1800 at tick3", snaps[3]); end
    end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL rock_scoreboard got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      if ({cg_at_done, w_at_done} !== e) begin errors++; $display("FAIL rock_result got %h want %h", {cg_at_done, w_at_done}, e); end
    end
    checks++; if ({busy_at_done, ready_at_done, done_after} !== 3'b010) begin errors++; $display("FAIL rock_done_pulse got busy=%b ready=%b done_next=%b want 0 1 0", busy_at_done, ready_at_done, done_after); end
  endtask

  task automatic test_rock_then_paper();
    exp_t e;
    build_expect(widths_now, table_of(2));
    repeat (3) send_beat(8'h02);
    push_expect(2);
    watch_ramp(200);
    checks++; if (timed_out) begin errors++; $display("FAIL paper_timeout got no done want done within 200 cycles"); end
    checks++; if (snaps.size() != 9) begin errors++; $display("FAIL paper_ticks got %0d want 9", snaps.size()); end
    for (int k = 0; k < snaps.size() && k < exp_snaps.size(); k++) begin
      checks++; if (snaps[k] !== exp_snaps[k]) begin errors++; $display("FAIL paper_tick%0d got %h want %h", k + 1, snaps[k], exp_snaps[k]); end
    end
    for (int k = 1; k < gaps.size(); k++) begin
      checks++; if (gaps[k] != TICK) begin errors++; $display("FAIL paper_gap%0d got %0d want %0d", k, gaps[k], TICK); end
    end
    if (snaps.size() >= 9) begin
      checks++; if (snaps[5][15:0] !== 16'd1400 || snaps[6][15:0] !== 16'd1300 || snaps[8][79:64] !== 16'd1000) begin errors++; $display("FAIL paper_pinky_thumb got t6=%h t7=%h t9=%h want pinky 1400,1300 thumb 1000", snaps[5], snaps[6], snaps[8]); end
    end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL paper_scoreboard got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      if ({cg_at_done, w_at_done} !== e) begin errors++; $display("FAIL paper_result got %h want %h", {cg_at_done, w_at_done}, e); end
    end
  endtask

  task automatic test_noop();
    logic [79:0] held;
    logic [7:0] codes[5];
    codes = '{8'h01, 8'h00, 8'h01, 8'h07, 8'h02};
    held = widths_now;
    foreach (codes[k]) begin
      send_beat(codes[k]);
      checks++; if ({gesture_ready, busy} !== 2'b10) begin errors++; $display("FAIL noop_beat%0d got ready=%b busy=%b want 1 0", k, gesture_ready, busy); end
    end
    send_beat(8'h01);
    send_beat(8'h01);
    repeat (12) @(negedge clk);
    checks++; if (widths_now !== held) begin errors++; $display("FAIL noop_widths got %h want %h", widths_now, held); end
    checks++; if ({busy, current_gesture, gesture_ready} !== 4'b0101) begin errors++; $display("FAIL noop_state got busy=%b cg=%0d ready=%b want 0 2 1", busy, current_gesture, gesture_ready); end
  endtask

  task automatic test_reset_mid_ramp();
    bit seen;
    send_beat(8'h00);
    repeat (3) send_beat(8'h01);
    push_expect(1);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (width_thumb == 16'd1700) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL midramp_reach got thumb=%0d want 1700 within 200 cycles", width_thumb); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    checks++; if (widths_now !== ALL1500) begin errors++; $display("FAIL midramp_widths got %h want %h", widths_now, ALL1500); end
    checks++; if ({busy, done, current_gesture, gesture_ready} !== 5'b00000) begin errors++; $display("FAIL midramp_flags got busy=%b done=%b cg=%0d ready=%b want 0 0 0 0", busy, done, current_gesture, gesture_ready); end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy || widths_now != ALL1500) seen = 1'b1;
    end
    checks++; if (seen || gesture_ready !== 1'b1) begin errors++; $display("FAIL midramp_after got activity=%b ready=%b want 0 1", seen, gesture_ready); end
  endtask

  task automatic test_debounce_restart();
    exp_t e;
    logic [7:0] codes[4];
    codes = '{8'h01, 8'h01, 8'h02, 8'h02};
    build_expect(widths_now, table_of(2));
    foreach (codes[k]) begin
      send_beat(codes[k]);
      checks++; if (widths_now !== ALL1500 || busy !== 1'b0) begin errors++; $display("FAIL debounce_beat%0d got widths=%h busy=%b want %h 0", k, widths_now, busy, ALL1500); end
    end
    send_beat(8'h02);
    push_expect(2);
    watch_ramp(200);
    checks++; if (timed_out) begin errors++; $display("FAIL debounce_timeout got no done want done within 200 cycles"); end
    checks++; if (snaps.size() != 5) begin errors++; $display("FAIL debounce_ticks got %0d want 5", snaps.size()); end
    for (int k = 0; k < snaps.size() && k < exp_snaps.size(); k++) begin
      checks++; if (snaps[k] !== exp_snaps[k]) begin errors++; $display("FAIL debounce_tick%0d got %h want %h", k + 1, snaps[k], exp_snaps[k]); end
    end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL debounce_scoreboard got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      if ({cg_at_done, w_at_done} !== e) begin errors++; $display("FAIL debounce_result got %h want %h", {cg_at_done, w_at_done}, e); end
    end
    checks++; if (ready_at_done !== 1'b1) begin errors++; $display("FAIL debounce_ready_after_done got %b want 1", ready_at_done); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    build_expect(widths_now, table_of(3));
    repeat (3) send_beat(8'h03);
    push_expect(3);
    watch_ramp(200);
    checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout got no done want done within 200 cycles"); end
    checks++; if (snaps.size() != 9) begin errors++; $display("FAIL b2b_ticks got %0d want 9", snaps.size()); end
    for (int k = 0; k < snaps.size() && k < exp_snaps.size(); k++) begin
      checks++; if (snaps[k] !== exp_snaps[k]) begin errors++; $display("FAIL b2b_tick%0d got %h want %h", k + 1, snaps[k], exp_snaps[k]); end
    end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL b2b_scoreboard got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      if ({cg_at_done, w_at_done} !== e) begin errors++; $display("FAIL b2b_result got %h want %h", {cg_at_done, w_at_done}, e); end
    end
    checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL b2b_done_width got done_next=%b want 0", done_after); end
  endtask

  initial begin
    test_reset();
    test_rock();
    test_rock_then_paper();
    test_noop();
    test_reset_mid_ramp();
    test_debounce_restart();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gesture_sequencer.md
Name: gesture_sequencer

Overview:
- Sits between the gesture source (classifier/UART front end) and the five servo_pwm generators. Produces the per-finger pulse widths.
- Accepts gesture codes over a valid/ready handshake and debounces them: a code must repeat STABLE_COUNT consecutive times before it is applied.
- Slews each finger width toward its target at a bounded rate, so the servos never see step jumps.
- Holds the current widths between gestures.

Parameters:
- TICK_CYCLES, 50000, clk cycles per slew tick (1 ms at 50 MHz); must be >= 2.
- STEP_US, 16'd10, maximum width change per finger per tick, in µs; must be > 0.
- STABLE_COUNT, 3, consecutive identical accepted beats required to commit a gesture; must be >= 1.
- WIDTH_MIN, 16'd1000, lower clamp applied to targets.
- WIDTH_MAX, 16'd2000, upper clamp applied to targets.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- gesture_valid  in  1  gesture beat is present
- gesture  in  8  gesture code: 1=Rock, 2=Paper, 3=Scissors; 0 and all other codes are no-op
- gesture_ready  out  1  sequencer can accept a beat
- width_thumb  out  16  pulse width in µs to the thumb servo_pwm
- width_index  out  16  pulse width in µs to the index servo_pwm
- width_middle  out  16  pulse width in µs to the middle servo_pwm
- width_ring  out  16  pulse width in µs to the ring servo_pwm
- width_pinky  out  16  pulse width in µs to the pinky servo_pwm
- busy  out  1  ramp in progress
- done  out  1  one-cycle pulse when a ramp completes
- current_gesture  out  2  last fully applied gesture; 0 = none

Behaviour:
- Reset, sampled on the clk rising edge:
  - all widths = 1500; targets = 1500.
  - state = IDLE; tick counter = 0; qualify count = 0; candidate = 0.
  - current_gesture = 0; busy = 0; done = 0.
  - gesture_ready = 0 while reset is high.
- Reset wins over every other event in the same cycle, including mid-ramp. Widths snap to 1500 on the next edge.
- Handshake:
  - A beat is accepted on a cycle with gesture_valid && gesture_ready.
  - gesture_ready = 1 in IDLE and QUALIFY; 0 in RAMP. It is decoded from registered state.
- Target table (targets are clamped to [WIDTH_MIN, WIDTH_MAX]), as thumb/index/middle/ring/pinky:
  - Rock: 1900/1900/1800/2000/2000.
  - Paper: 1000/1100/1000/1100/1300.
  - Scissors: 1800/1100/1000/2000/2000.
- Tick generator:
  - Free-running counter 0..TICK_CYCLES-1. tick = 1 on the count TICK_CYCLES-1, then the counter wraps to 0.
  - The counter runs in every state and is cleared only by reset.
- IDLE:
  - Accepted beat with a valid code (1–3) that differs from current_gesture: candidate = code, count = 1.
    - If STABLE_COUNT = 1, load targets and go to RAMP.
    - Otherwise go to QUALIFY.
  - Code equal to current_gesture, 0, or unknown: beat is consumed and ignored; stay in IDLE.
- QUALIFY:
  - Accepted beat equal to candidate: count++. When count reaches STABLE_COUNT, load targets and go to RAMP on the same edge.
  - Accepted beat with a different valid code: restart with candidate = new code, count = 1.
    - If the new code equals current_gesture, go to IDLE instead.
  - Accepted 0 or unknown code: go to IDLE; count = 0.
  - No accepted beat: hold state and count. There is no timeout.
- RAMP:
  - busy = 1. Beats are not accepted.
  - On each tick cycle, each finger independently:
    - if width < target: width += min(STEP_US, target − width).
    - if width > target: width −= min(STEP_US, width − target).
  - Arithmetic is 16-bit unsigned; differences are computed by magnitude compare, never by a wrapped subtract. Targets never overshoot.
  - When all five widths equal their targets, on that edge: go to IDLE, current_gesture = candidate, done = 1 for exactly one cycle, busy = 0.
  - First width change occurs on the first tick edge after entering RAMP. A tick in the entry cycle itself does not count.
- Outputs are all registered. Widths change only in RAMP on tick edges, or on reset.
- Back-to-back: gesture_ready is 1 in the cycle after done, so a new gesture can start qualifying immediately.

Test Plan:
(All with TICK_CYCLES=4, STEP_US=100, STABLE_COUNT=3.)
- Reset:
  - Stimulus: hold reset 2 cycles, then release.
  - Required: all widths = 1500, busy = 0, done = 0, current_gesture = 0; gesture_ready = 0 during reset and 1 on the first cycle after.
- Rock:
  - Stimulus: 3 accepted beats of 8'h01.
  - Required: busy = 1, gesture_ready = 0.
  - Thumb 1500→1600→1700→1800→1900 over 4 ticks; middle holds 1800 after tick 3; ring and pinky reach 2000 at tick 5.
  - done pulses 1 cycle on that edge; current_gesture = 1.
- Rock then Paper:
  - Stimulus: from Rock, 3 beats of 8'h02.
  - Required: pinky 2000→1300 in 7 ticks of −100; thumb reaches 1000 at tick 9; done only after tick 9.
- Debounce restart:
  - Stimulus: beats 1, 1, 2, 2, 2.
  - Required: Paper targets applied; Rock never applied; no width change before the 5th beat.
- No-op codes:
  - Stimulus: beats 1, 0, 1, 8'h07, and a repeat of current_gesture from IDLE.
  - Required: return to IDLE; widths, current_gesture and busy unchanged; gesture_ready stays 1.
- Reset mid-ramp:
  - Stimulus: assert reset during a Rock ramp at width_thumb = 1700.
  - Required: next edge all widths = 1500, state IDLE, busy = 0, no done pulse, current_gesture = 0.
